i2c_master_ctrl: RTL and testbench
==================================

// Module: i2c_master_ctrl
// PURPOSE
//  Synthesizable single-byte I2C master: executes one command (START, 7-bit addr + R/W, one data byte, STOP).
//  Drives open-drain SCL/SDA through output-enable pins (oe=1 pulls line low, oe=0 releases).
//  Sits between the register/command fabric and the board I2C pads; simulation-paired with the team's slave BFM.
// PARAMETERS
//  CLK_FREQ  100_000_000  system clock frequency, Hz
//  I2C_FREQ  100_000      SCL bit rate, Hz; DIV = CLK_FREQ/(4*I2C_FREQ) clk cycles per quarter-bit (DIV>=2, elaboration check)
// PORTS
//  clk        in   1  system clock
//  rst_n      in   1  asynchronous active-low reset
//  cmd_valid  in   1  command request
//  cmd_ready  out  1  high only in IDLE; handshake = cmd_valid & cmd_ready
//  cmd_addr   in   7  target address, sent MSB first
//  cmd_rw     in   1  R/W bit on the wire: 0 = write, 1 = read
//  cmd_wdata  in   8  write byte, MSB first (ignored for reads)
//  rsp_valid  out  1  one-cycle pulse when STOP completes
//  rsp_rdata  out  8  read byte (held until next rsp_valid; 8'h00 for writes)
//  rsp_nack   out  1  1 = addr or write-data NACK seen; valid with rsp_valid
//  busy       out  1  high from handshake until rsp_valid cycle inclusive
//  scl_oe     out  1  1 = pull SCL low
//  sda_oe     out  1  1 = pull SDA low
//  scl_i      in   1  SCL pad sense
//  sda_i      in   1  SDA pad sense (synchronized by 2 flops internally)
// BEHAVIOUR
//  Reset (async, immediate): scl_oe=0, sda_oe=0, cmd_ready=1, busy=0, rsp_valid=0, rsp_rdata=0, rsp_nack=0, FSM=IDLE.
//  Reset mid-transfer releases both lines at once; no STOP generated.
//  Tick: counter 0..DIV-1, reloads on wrap; cleared on handshake; each wrap advances one quarter (Q0..Q3).
//  Data bit: Q0,Q1 SCL low (SDA updated at start of Q0); Q2,Q3 SCL released; sda_i sampled first cycle of Q3.
//  START bit-time: Q0-Q1 both released; Q2 SDA low; Q3 SCL low.
//  STOP bit-time: Q0 SCL low, SDA low; Q1 SCL released; Q2 SDA released; Q3 idle -> rsp_valid.
//  FSM: IDLE -> START -> ADDR(8 bits: addr[6:0], rw) -> AACK -> {WDATA->WACK | RDATA->RACK} -> STOP -> IDLE.
//  AACK: sda_i=1 -> rsp_nack=1, skip data, go STOP. WACK: sda_i=1 -> rsp_nack=1; always then STOP.
//  RDATA: SDA released, 8 samples shifted MSB first. RACK: master NACKs (SDA released), then STOP.
//  Latency: no stretch -> rsp_valid exactly 80*DIV+1 clk after handshake cycle; AACK NACK -> 44*DIV+1.
//  cmd_valid while busy: ignored (cmd_ready=0). Command fields latched on handshake only.
//  rsp_valid and new handshake may not coincide: cmd_ready rises the cycle after rsp_valid.
// CONFIGURATION
//  I2C_CLK_STRETCH_EN defined: on entering Q2, tick counter holds while scl_i==0 (slave stretch);
//   latency grows by stretch cycles; STOP Q1 also honours stretch.
//  Not defined: scl_i unused, fixed timing as above.
// STRUCTURE
//  i2c_pkg: i2c_state_e enum (IDLE,START,ADDR,AACK,WDATA,WACK,RDATA,RACK,STOP),
//   localparams I2C_RW_WRITE=1'b0, I2C_RW_READ=1'b1, I2C_ACK=1'b0, I2C_NACK=1'b1.
//  Sub-module i2c_tick_gen: quarter-bit divider (clk, rst_n, clr, hold, tick, qtr[1:0]).
//  Top: FSM, bit counter (0..7), 8-bit shift register, sda_i synchronizer, output regs.
// TESTING  (CLK_FREQ=100e6, I2C_FREQ=100e3, DIV=250)
//  Write addr 7'h50 data 8'hA5, slave ACKs -> bus shows S,0xA0,A,0xA5,A,P; rsp_nack=0; rsp_valid at 20001 clk.
//  Read addr 7'h50, slave returns 8'h5B -> bus 0xA1, master NACK, P; rsp_rdata=8'h5B, rsp_nack=0.
//  Write addr 7'h3C, no slave (SDA pulled up) -> 0x78 then NACK, P; rsp_nack=1, rsp_valid at 11001 clk.
//  rst_n low mid-ADDR -> scl_oe=sda_oe=0 same cycle; after release cmd_ready=1; next write completes normally.
//  cmd_valid held during transfer with changed fields -> only first command on bus; one rsp_valid.
//  I2C_CLK_STRETCH_EN: slave holds SCL low 1000 clk at WACK -> rsp_valid at 21001 clk; data intact.

Source files
------------

// File: rtl/i2c_pkg.sv
// Package: i2c_pkg
// Shared types and constants for the single-byte I2C master.
//   i2c_state_e   - controller FSM states
//   I2C_RW_*      - R/W bit values as they appear on the wire
//   I2C_ACK/NACK  - acknowledge bit values as they appear on the wire
//   i2c_addr_byte - builds the first byte of a transfer {addr, rw}
package i2c_pkg;

   typedef enum logic [3:0] {
      IDLE,
      START,
      ADDR,
      AACK,
      WDATA,
      WACK,
      RDATA,
      RACK,
      STOP
   } i2c_state_e;

   localparam logic I2C_RW_WRITE = 1'b0;
   localparam logic I2C_RW_READ  = 1'b1;
   localparam logic I2C_ACK      = 1'b0;
   localparam logic I2C_NACK     = 1'b1;

   function automatic logic [7:0] i2c_addr_byte(input logic [6:0] addr, input logic rw);
      return {addr, rw};
   endfunction

endpackage

// File: rtl/i2c_tick_gen.sv
// Module: i2c_tick_gen
// Quarter-bit timebase. A counter runs 0..DIV-1; each wrap produces a
// one-cycle registered tick and advances the quarter index qtr (Q0..Q3).
// Ports:
//   clk, rst_n - system clock, asynchronous active-low reset
//   clr        - restart the timebase at Q0 with the counter at zero
//   hold       - freeze the counter (clock stretching); no tick while held
//   tick       - one-cycle pulse: qtr has just moved to a new quarter
//   qtr        - current quarter index
module i2c_tick_gen #(
   parameter int DIV = 250
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr,
   input  logic       hold,
   output logic       tick,
   output logic [1:0] qtr
);

   localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt  <= '0;
         tick <= 1'b0;
         qtr  <= 2'd0;
      end else if (clr) begin
         cnt  <= '0;
         tick <= 1'b0;
         qtr  <= 2'd0;
      end else if (hold) begin
         tick <= 1'b0;
      end else if (cnt == CW'(DIV - 1)) begin
         cnt  <= '0;
         tick <= 1'b1;
         qtr  <= qtr + 2'd1;
      end else begin
         cnt  <= cnt + 1'b1;
         tick <= 1'b0;
      end
   end

endmodule

// File: rtl/i2c_master_ctrl.sv
// Module: i2c_master_ctrl
// Single-byte I2C master: START, 7-bit address + R/W, one data byte, STOP.
// SCL/SDA are open drain: *_oe=1 pulls the line low, 0 releases it.
// Optional feature macro: I2C_CLK_STRETCH_EN - when defined, the quarter
// timebase freezes while SCL is released by us but still sensed low.
// Ports:
//   cmd_valid/cmd_ready         - command handshake, cmd_ready high only in IDLE
//   cmd_addr/cmd_rw/cmd_wdata   - command fields, latched on the handshake
//   rsp_valid                   - one-cycle pulse when the STOP completes
//   rsp_rdata/rsp_nack          - read byte (0 for writes) and NACK flag
//   busy                        - handshake through rsp_valid cycle inclusive
//   scl_oe/sda_oe               - pad pull-down enables
//   scl_i/sda_i                 - pad senses (sda_i synchronized here)
// Handshake rule: a command transfers on a cycle where cmd_valid and
// cmd_ready are both high; cmd_ready is a register that is low from the
// handshake until the cycle after rsp_valid, so the two never coincide.
module i2c_master_ctrl
   import i2c_pkg::*;
#(
   parameter int CLK_FREQ = 100_000_000,
   parameter int I2C_FREQ = 100_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [6:0] cmd_addr,
   input  logic       cmd_rw,
   input  logic [7:0] cmd_wdata,
   output logic       rsp_valid,
   output logic [7:0] rsp_rdata,
   output logic       rsp_nack,
   output logic       busy,
   output logic       scl_oe,
   output logic       sda_oe,
   input  logic       scl_i,
   input  logic       sda_i
);

   localparam int DIV = CLK_FREQ / (4 * I2C_FREQ);

   if (DIV < 2) begin : g_div_check
      $error("i2c_master_ctrl: CLK_FREQ/(4*I2C_FREQ) must be at least 2");
   end

   i2c_state_e state;
   logic [2:0] bit_cnt;
   logic [7:0] shreg;
   logic       rw_q;
   logic [7:0] wdata_q;
   logic       ack_smp;
   logic       nack_flag;
   logic       sda_meta;
   logic       sda_sync;
   logic       tick;
   logic [1:0] qtr;
   logic       clr;
   logic       hold;

   assign clr = cmd_valid & cmd_ready;

`ifdef I2C_CLK_STRETCH_EN
   // Released SCL that still reads low means a slave is stretching the clock.
   assign hold = (state != IDLE) && !scl_oe && !scl_i;
`else
   logic unused_scl_i;
   assign hold         = 1'b0;
   assign unused_scl_i = scl_i;
`endif

   i2c_tick_gen #(.DIV(DIV)) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .hold  (hold),
      .tick  (tick),
      .qtr   (qtr)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sda_meta <= 1'b1;
         sda_sync <= 1'b1;
      end else begin
         sda_meta <= sda_i;
         sda_sync <= sda_meta;
      end
   end

   // Every action happens on a tick, i.e. on entry to quarter qtr. A tick
   // with qtr==0 closes the current bit-time and opens the next one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cmd_ready <= 1'b1;
         busy      <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= 8'h00;
         rsp_nack  <= 1'b0;
         scl_oe    <= 1'b0;
         sda_oe    <= 1'b0;
         bit_cnt   <= 3'd0;
         shreg     <= 8'h00;
         rw_q      <= 1'b0;
         wdata_q   <= 8'h00;
         ack_smp   <= 1'b0;
         nack_flag <= 1'b0;
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (cmd_valid && cmd_ready) begin
                  state     <= START;
                  cmd_ready <= 1'b0;
                  busy      <= 1'b1;
                  shreg     <= i2c_addr_byte(cmd_addr, cmd_rw);
                  rw_q      <= cmd_rw;
                  wdata_q   <= cmd_wdata;
                  nack_flag <= 1'b0;
                  scl_oe    <= 1'b0;
                  sda_oe    <= 1'b0;
               end else begin
                  cmd_ready <= 1'b1;
                  busy      <= 1'b0;
               end
            end
            START: if (tick) begin
               case (qtr)
                  2'd2: sda_oe <= 1'b1;
                  2'd3: scl_oe <= 1'b1;
                  2'd0: begin
                     state   <= ADDR;
                     bit_cnt <= 3'd0;
                     sda_oe  <= ~shreg[7];
                  end
                  default: ;
               endcase
            end
            ADDR, WDATA: if (tick) begin
               case (qtr)
                  2'd2: scl_oe <= 1'b0;
                  2'd0: begin
                     scl_oe <= 1'b1;
                     if (bit_cnt == 3'd7) begin
                        state  <= (state == ADDR) ? AACK : WACK;
                        sda_oe <= 1'b0;
                     end else begin
                        bit_cnt <= bit_cnt + 3'd1;
                        shreg   <= {shreg[6:0], 1'b0};
                        sda_oe  <= ~shreg[6];
                     end
                  end
                  default: ;
               endcase
            end
            AACK, WACK: if (tick) begin
               case (qtr)
                  2'd2: scl_oe  <= 1'b0;
                  2'd3: ack_smp <= sda_sync;
                  2'd0: begin
                     scl_oe <= 1'b1;
                     if (ack_smp == I2C_NACK || state == WACK) begin
                        // STOP opens with SCL and SDA both low.
                        nack_flag <= (ack_smp == I2C_NACK);
                        state     <= STOP;
                        sda_oe    <= 1'b1;
                     end else if (rw_q == I2C_RW_WRITE) begin
                        state   <= WDATA;
                        bit_cnt <= 3'd0;
                        shreg   <= wdata_q;
                        sda_oe  <= ~wdata_q[7];
                     end else begin
                        state   <= RDATA;
                        bit_cnt <= 3'd0;
                        sda_oe  <= 1'b0;
                     end
                  end
                  default: ;
               endcase
            end
            RDATA: if (tick) begin
               case (qtr)
                  2'd2: scl_oe <= 1'b0;
                  2'd3: shreg  <= {shreg[6:0], sda_sync};
                  2'd0: begin
                     scl_oe <= 1'b1;
                     if (bit_cnt == 3'd7) state <= RACK;
                     else bit_cnt <= bit_cnt + 3'd1;
                  end
                  default: ;
               endcase
            end
            RACK: if (tick) begin
               // SDA stays released: the master NACKs its single read byte.
               case (qtr)
                  2'd2: scl_oe <= 1'b0;
                  2'd0: begin
                     scl_oe <= 1'b1;
                     sda_oe <= 1'b1;
                     state  <= STOP;
                  end
                  default: ;
               endcase
            end
            STOP: if (tick) begin
               case (qtr)
                  2'd1: scl_oe <= 1'b0;
                  2'd2: sda_oe <= 1'b0;
                  2'd0: begin
                     state     <= IDLE;
                     rsp_valid <= 1'b1;
                     rsp_nack  <= nack_flag;
                     rsp_rdata <= (rw_q == I2C_RW_READ && !nack_flag) ? shreg : 8'h00;
                  end
                  default: ;
               endcase
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Testbench: tb_i2c_master_ctrl
// Drives commands into i2c_master_ctrl against a behavioural slave at
// address 7'h50 on a wired-AND bus. Bytes seen on the bus and responses
// are checked against expected queues filled when each command is driven.
module tb_i2c_master_ctrl;

   localparam int CLK_FREQ = 100_000_000;
   localparam int I2C_FREQ = 100_000;
   localparam int DIV      = CLK_FREQ / (4 * I2C_FREQ);
   localparam logic [6:0] SLAVE_ADDR = 7'h50;

   typedef struct {
      logic [6:0] addr;
      logic       rw;
      logic [7:0] wdata;
      logic [7:0] rd_byte;
      logic       exp_nack;
      logic [7:0] exp_rdata;
      int         exp_lat;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [6:0] cmd_addr = 7'h00;
   logic       cmd_rw = 1'b0;
   logic [7:0] cmd_wdata = 8'h00;
   logic       rsp_valid;
   logic [7:0] rsp_rdata;
   logic       rsp_nack;
   logic       busy;
   logic       scl_oe;
   logic       sda_oe;
   logic       scl_bus;
   logic       sda_bus;

   // slave model state
   logic       s_scl_hold = 1'b0;
   logic       s_sda_low;
   logic [7:0] s_rd_byte = 8'h00;
   logic       s_active;
   int         s_bitn;
   logic [7:0] s_sh;
   logic       s_rw;
   logic       s_hit;
   logic       scl_p;
   logic       sda_p;
   int         stop_cnt = 0;

   int n_cmp = 0;
   int n_err = 0;
   logic [8:0] exp_bus_q[$];
   logic [8:0] exp_rsp_q[$];

   assign scl_bus = ~scl_oe & ~s_scl_hold;
   assign sda_bus = ~sda_oe & ~s_sda_low;

   i2c_master_ctrl #(.CLK_FREQ(CLK_FREQ), .I2C_FREQ(I2C_FREQ)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_addr  (cmd_addr),
      .cmd_rw    (cmd_rw),
      .cmd_wdata (cmd_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_nack  (rsp_nack),
      .busy      (busy),
      .scl_oe    (scl_oe),
      .sda_oe    (sda_oe),
      .scl_i     (scl_bus),
      .sda_i     (sda_bus)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic bus_item(input logic [7:0] b, input logic a);
      logic [8:0] e;
      if (exp_bus_q.size() == 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL bus_extra: got byte %02h ack %0b, required nothing on bus", b, a);
      end else begin
         e = exp_bus_q.pop_front();
         check("bus_byte_ack", {23'd0, b, a}, {23'd0, e});
      end
   endtask

   task automatic check_rsp();
      logic [8:0] e;
      if (exp_rsp_q.size() == 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL rsp_extra: got rsp_valid, required none");
      end else begin
         e = exp_rsp_q.pop_front();
         check("rsp_nack", {31'd0, rsp_nack}, {31'd0, e[8]});
         check("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, e[7:0]});
      end
      check("busy_at_rsp", {31'd0, busy}, 32'd1);
      check("ready_at_rsp", {31'd0, cmd_ready}, 32'd0);
   endtask

   always @(negedge clk) begin
      if (rst_n && rsp_valid) check_rsp();
   end

   // ---------------- behavioural slave + bus monitor ----------------
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_active  <= 1'b0;
         s_bitn    <= 0;
         s_sda_low <= 1'b0;
         s_sh      <= 8'h00;
         s_rw      <= 1'b0;
         s_hit     <= 1'b0;
         scl_p     <= 1'b1;
         sda_p     <= 1'b1;
      end else begin
         scl_p <= scl_bus;
         sda_p <= sda_bus;
         if (scl_p && scl_bus && sda_p && !sda_bus) begin
            s_active  <= 1'b1;
            s_bitn    <= 0;
            s_hit     <= 1'b0;
            s_sda_low <= 1'b0;
         end else if (scl_p && scl_bus && !sda_p && sda_bus) begin
            if (s_active) stop_cnt <= stop_cnt + 1;
            s_active  <= 1'b0;
            s_sda_low <= 1'b0;
         end else if (s_active && !scl_p && scl_bus) begin
            s_bitn <= s_bitn + 1;
            if (s_bitn == 8 || s_bitn == 17) bus_item(s_sh, sda_bus);
            else s_sh <= {s_sh[6:0], sda_bus};
            if (s_bitn == 7) begin
               s_rw  <= sda_bus;
               s_hit <= (s_sh[6:0] == SLAVE_ADDR);
            end
         end else if (s_active && scl_p && !scl_bus) begin
            if (s_bitn == 8) s_sda_low <= s_hit;
            else if (s_bitn >= 9 && s_bitn <= 16) s_sda_low <= s_hit && s_rw && !s_rd_byte[16 - s_bitn];
            else if (s_bitn == 17) s_sda_low <= s_hit && !s_rw;
            else s_sda_low <= 1'b0;
         end
      end
   end

   // ---------------- driver ----------------
   // Issues one command, optionally keeps cmd_valid high with altered
   // fields for the whole transfer, and measures handshake->rsp_valid.
   task automatic run_cmd(input vec_t v, input bit hold_valid);
      int  cyc;
      bit  hit;
      cyc = 0;
      @(negedge clk);
      while (!cmd_ready && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      check("ready_before_cmd", {31'd0, cmd_ready}, 32'd1);
      cmd_addr  = v.addr;
      cmd_rw    = v.rw;
      cmd_wdata = v.wdata;
      s_rd_byte = v.rd_byte;
      cmd_valid = 1'b1;
      hit = (v.addr == SLAVE_ADDR);
      exp_bus_q.push_back({v.addr, v.rw, ~hit});
      if (hit) begin
         if (v.rw) exp_bus_q.push_back({v.rd_byte, 1'b1});
         else      exp_bus_q.push_back({v.wdata, 1'b0});
      end
      exp_rsp_q.push_back({v.exp_nack, v.exp_rdata});
      @(posedge clk);
      @(negedge clk);
      check("busy_after_hs", {31'd0, busy}, 32'd1);
      if (hold_valid) begin
         cmd_addr  = 7'h3C;
         cmd_rw    = ~v.rw;
         cmd_wdata = ~v.wdata;
      end else begin
         cmd_valid = 1'b0;
      end
      cyc = 0;
      while (!rsp_valid && cyc < v.exp_lat + 1000) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
      end
      cmd_valid = 1'b0;
      check("latency", cyc, v.exp_lat);
      @(negedge clk);
      check("ready_after_rsp", {31'd0, cmd_ready}, 32'd1);
      check("busy_after_rsp", {31'd0, busy}, 32'd0);
      check("rsp_valid_pulse", {31'd0, rsp_valid}, 32'd0);
   endtask

   // ---------------- test sequence ----------------
   vec_t vecs[3];
   vec_t v;
   int   exp_stops;

   initial begin
      vecs[0] = '{addr: 7'h50, rw: 1'b0, wdata: 8'hA5, rd_byte: 8'h00,
                  exp_nack: 1'b0, exp_rdata: 8'h00, exp_lat: 80 * DIV + 1};
      vecs[1] = '{addr: 7'h50, rw: 1'b1, wdata: 8'h00, rd_byte: 8'h5B,
                  exp_nack: 1'b0, exp_rdata: 8'h5B, exp_lat: 80 * DIV + 1};
      vecs[2] = '{addr: 7'h3C, rw: 1'b0, wdata: 8'hC3, rd_byte: 8'h00,
                  exp_nack: 1'b1, exp_rdata: 8'h00, exp_lat: 44 * DIV + 1};
      exp_stops = 0;

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_scl_oe", {31'd0, scl_oe}, 32'd0);
      check("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
      check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rst_rsp_rdata", {24'd0, rsp_rdata}, 32'd0);
      check("rst_rsp_nack", {31'd0, rsp_nack}, 32'd0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      // table-driven transfers
      for (int i = 0; i < 3; i++) begin
         run_cmd(vecs[i], 1'b0);
         exp_stops++;
         repeat (10) @(negedge clk);
      end

      // reset in the middle of the address byte
      @(negedge clk);
      cmd_addr  = 7'h50;
      cmd_rw    = 1'b0;
      cmd_wdata = 8'h77;
      cmd_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (6 * DIV) @(posedge clk);
      @(negedge clk);
      check("mid_addr_busy", {31'd0, busy}, 32'd1);
      check("mid_addr_scl_low", {31'd0, scl_oe}, 32'd1);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_scl_oe", {31'd0, scl_oe}, 32'd0);
      check("async_rst_sda_oe", {31'd0, sda_oe}, 32'd0);
      check("async_rst_busy", {31'd0, busy}, 32'd0);
      check("async_rst_ready", {31'd0, cmd_ready}, 32'd1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_ready", {31'd0, cmd_ready}, 32'd1);

      // cmd_valid held with changed fields: only the first command runs
      v = '{addr: 7'h50, rw: 1'b0, wdata: 8'h96, rd_byte: 8'h00,
            exp_nack: 1'b0, exp_rdata: 8'h00, exp_lat: 80 * DIV + 1};
      run_cmd(v, 1'b1);
      exp_stops++;
      repeat (10) @(negedge clk);

`ifdef I2C_CLK_STRETCH_EN
      // slave stretches SCL for 1000 cycles during the write ACK bit
      v = '{addr: 7'h50, rw: 1'b0, wdata: 8'h3E, rd_byte: 8'h00,
            exp_nack: 1'b0, exp_rdata: 8'h00, exp_lat: 80 * DIV + 1 + 1000};
      fork
         run_cmd(v, 1'b0);
         begin
            int   falls;
            int   guard;
            logic prev;
            falls = 0;
            guard = 0;
            prev  = 1'b0;
            while (falls < 18 && guard < 30000) begin
               @(negedge clk);
               guard++;
               if (prev && !scl_oe) falls++;
               prev = scl_oe;
            end
            s_scl_hold = 1'b1;
            repeat (1000) @(posedge clk);
            @(negedge clk);
            s_scl_hold = 1'b0;
         end
      join
      exp_stops++;
      repeat (10) @(negedge clk);
`endif

      check("bus_queue_drained", exp_bus_q.size(), 32'd0);
      check("rsp_queue_drained", exp_rsp_q.size(), 32'd0);
      check("stop_count", stop_cnt, exp_stops);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
